iqx4_and_time_deadlock_reporter: RTL

Downstream consumer of the iqx4_and_time deadlock monitor's `block` output. It qualifies the raw per-cycle block indication with a programmable persistence threshold, declares a sticky deadlock, and raises a one-cycle interrupt. It keeps stall-length and event statistics and snapshots which AXI-Stream interface was blocking, for readout by the control/status register block.

---
 rtl/iqx4_and_time_deadlock_reporter.sv | 109 ++++++++++
 1 files changed

// File: rtl/iqx4_and_time_deadlock_reporter.sv
// Qualifies the deadlock monitor's block flag against a persistence threshold,
// latches a sticky deadlock with one-shot irq, and keeps stall/event statistics.
module iqx4_and_time_deadlock_reporter #(
   parameter int unsigned N_SIGS   = 3,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned THRESH_W = 16,
   parameter int unsigned EVT_W    = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                block,
   input  logic [N_SIGS-1:0]   axis_block_sigs,
   input  logic [THRESH_W-1:0] threshold,
   input  logic                clear,
   output logic                deadlock,
   output logic                irq,
   output logic [CNT_W-1:0]    stall_cycles,
   output logic [CNT_W-1:0]    max_stall,
   output logic [EVT_W-1:0]    event_count,
   output logic [N_SIGS-1:0]   culprit
);

   localparam int unsigned CMP_W = (CNT_W > THRESH_W) ? CNT_W : THRESH_W;

   typedef enum logic [1:0] {IDLE, STALL, DEADLOCK} state_t;

   state_t              state_q, state_d;
   logic                deadlock_q, deadlock_d;
   logic                irq_q, irq_d;
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic [CNT_W-1:0]    max_q, max_d;
   logic [EVT_W-1:0]    evt_q, evt_d;
   logic [N_SIGS-1:0]   culprit_q, culprit_d;

   logic [THRESH_W-1:0] thr_eff;
   logic [CNT_W-1:0]    stall_inc;
   logic                thr_is_one;
   logic                inc_hit;
   logic                declare;

   assign thr_eff    = (threshold == '0) ? THRESH_W'(1) : threshold;
   assign stall_inc  = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
   assign thr_is_one = (thr_eff == THRESH_W'(1));
   // Equality-only compare: a threshold lowered below the running count never fires this run.
   assign inc_hit    = (CMP_W'(stall_inc) == CMP_W'(thr_eff));
   assign declare    = !clear && block &&
                       (((state_q == IDLE) && thr_is_one) || ((state_q == STALL) && inc_hit));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         deadlock_q <= 1'b0;
         irq_q      <= 1'b0;
         stall_q    <= '0;
         max_q      <= '0;
         evt_q      <= '0;
         culprit_q  <= '0;
      end else begin
         state_q    <= state_d;
         deadlock_q <= deadlock_d;
         irq_q      <= irq_d;
         stall_q    <= stall_d;
         max_q      <= max_d;
         evt_q      <= evt_d;
         culprit_q  <= culprit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (block) state_d = thr_is_one ? DEADLOCK : STALL;
         STALL:    if (block) state_d = inc_hit ? DEADLOCK : STALL;
                   else       state_d = IDLE;
         DEADLOCK: state_d = DEADLOCK;
         default:  state_d = IDLE;
      endcase
      if (clear) state_d = IDLE;
   end

   always_comb begin
      stall_d    = stall_q;
      deadlock_d = deadlock_q;
      irq_d      = declare;
      culprit_d  = culprit_q;
      evt_d      = evt_q;
      if (clear) begin
         stall_d    = '0;
         deadlock_d = 1'b0;
         culprit_d  = '0;
      end else if (block) begin
         stall_d = (state_q == IDLE) ? CNT_W'(1) : stall_inc;
      end
      if (declare) begin
         deadlock_d = 1'b1;
         culprit_d  = axis_block_sigs;
         evt_d      = (evt_q == '1) ? evt_q : evt_q + EVT_W'(1);
      end
      max_d = (stall_d > max_q) ? stall_d : max_q;
   end

   assign deadlock     = deadlock_q;
   assign irq          = irq_q;
   assign stall_cycles = stall_q;
   assign max_stall    = max_q;
   assign event_count  = evt_q;
   assign culprit      = culprit_q;

endmodule
